// File: rtl/otter_lsu.sv
// Load/store unit between the core and the OTTER data memory; one access in flight.
// Latency from accept: store/error 2 cycles, load 3 cycles, illegal size 1 cycle.
// Backpressure: req_ready only in IDLE; response is held frozen until resp_ready.
module otter_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0]  req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BUS_WIDTH-1:0]  resp_rdata,
  output logic                  resp_err,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_size,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_error
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0]  wdata_q;
  logic [BUS_WIDTH-1:0]  rdata_q;
  logic                  err_q;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [BUS_WIDTH-1:0]  load_ext;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and memory strobes; strobes exist only in ACCESS so reset kills them at once
  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_next = (req_size == 2'b11) ? RESP : ACCESS;
      end
      ACCESS: begin
        if (mem_error) begin
          state_next = RESP;
        end else if (we_q) begin
          mem_wr     = 1'b1;
          state_next = RESP;
        end else begin
          mem_rd     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, error flag and extended load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rdata_q <= '0;
          err_q   <= (req_size == 2'b11);
        end
        ACCESS:  if (mem_error) err_q <= 1'b1;
        WAIT:    rdata_q <= load_ext;
        default: ;
      endcase
    end
  end

  // Lane select and sign/zero extension of the synchronous-read word
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // Write data replicated across lanes; memory byte enables pick the lane
  always_comb begin
    case (size_q)
      2'b00:   mem_wdata = {4{wdata_q[7:0]}};
      2'b01:   mem_wdata = {2{wdata_q[15:0]}};
      default: mem_wdata = wdata_q;
    endcase
  end

  assign mem_addr   = addr_q;
  assign mem_size   = size_q;
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_otter_lsu.sv
module tb_otter_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_error;

  otter_lsu #(.ADDR_WIDTH(32), .BUS_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  // Data memory model: 4 KiB, synchronous read, byte-lane writes, range/alignment errors
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

  assign mem_error = (mem_addr >= 32'h1000) || (mem_size == 2'b11) ||
                     (mem_size == 2'b01 && mem_addr[0]) ||
                     (mem_size == 2'b10 && mem_addr[1:0] != 2'b00);

  always @(posedge clk) begin
    if (mem_wr && !mem_error) begin
      case (mem_size)
        2'b00:   mem[mem_addr[11:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[8*mem_addr[1:0] +: 8];
        2'b01:   mem[mem_addr[11:2]][16*mem_addr[1] +: 16] <= mem_wdata[16*mem_addr[1] +: 16];
        default: mem[mem_addr[11:2]] <= mem_wdata;
      endcase
    end
    if (mem_rd) mem_rdata <= mem[mem_addr[11:2]];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_fail = 0;

  // Observations from the last transaction
  logic [31:0] o_rdata, o_wd;
  logic [1:0]  o_sz;
  logic        o_err, o_stable;
  int          o_lat, o_nwr, o_nrd;

  // Drive one request, push its expected response, collect observations
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                       input int hold);
    exp_t e;
    int guard;
    e.rdata = e_rdata; e.err = e_err; e.lat = e_lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    sb.push_back(e);
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    o_lat = 1; o_nwr = 0; o_nrd = 0; o_wd = '0; o_sz = '0;
    while (!resp_valid && o_lat < 20) begin
      if (mem_wr) begin o_nwr++; o_wd = mem_wdata; o_sz = mem_size; end
      if (mem_rd) o_nrd++;
      @(posedge clk); #1;
      o_lat++;
    end
    o_rdata = resp_rdata; o_err = resp_err; o_stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (mem_wr || mem_rd) begin o_nwr += int'(mem_wr); o_nrd += int'(mem_rd); end
      if (resp_valid !== 1'b1 || resp_err !== o_err || resp_rdata !== o_rdata || req_ready !== 1'b0)
        o_stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({resp_valid, resp_err, resp_rdata, mem_rd, mem_wr, mem_addr, mem_size, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rv=%b re=%b rd=%h mrd=%b mwr=%b ma=%h ms=%b mwd=%h required all zero",
               resp_valid, resp_err, resp_rdata, mem_rd, mem_wr, mem_addr, mem_size, mem_wdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: req_ready=%b resp_valid=%b required 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_word();
    exp_t e;
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
    e = sb.pop_front();
    n_cmp++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== e.lat) begin
      n_fail++;
      $display("FAIL sw_resp: rdata=%h err=%b lat=%0d required %h/%b/%0d", o_rdata, o_err, o_lat, e.rdata, e.err, e.lat);
    end
    n_cmp++;
    if (o_nwr !== 1 || o_nrd !== 0 || o_wd !== 32'hDEADBEEF || o_sz !== 2'b10) begin
      n_fail++;
      $display("FAIL sw_bus: wr=%0d rd=%0d wdata=%h size=%b required 1/0/deadbeef/10", o_nwr, o_nrd, o_wd, o_sz);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
    e = sb.pop_front();
    n_cmp++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== e.lat || o_nrd !== 1 || o_nwr !== 0) begin
      n_fail++;
      $display("FAIL lw_resp: rdata=%h err=%b lat=%0d rd=%0d wr=%0d required %h/%b/%0d/1/0",
               o_rdata, o_err, o_lat, o_nrd, o_nwr, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_byte();
    exp_t e;
    issue(1'b1, 2'b00, 1'b0, 32'h203, 32'h12345680, 32'h0, 1'b0, 2, 0);
    e = sb.pop_front();
    n_cmp++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== e.lat || o_nwr !== 1 || o_wd !== 32'h80808080) begin
      n_fail++;
      $display("FAIL sb_store: rdata=%h err=%b lat=%0d wr=%0d wdata=%h required %h/%b/%0d/1/80808080",
               o_rdata, o_err, o_lat, o_nwr, o_wd, e.rdata, e.err, e.lat);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0);
    e = sb.pop_front();
    n_cmp++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== e.lat) begin
      n_fail++;
      $display("FAIL lb_signed: rdata=%h err=%b lat=%0d required %h/%b/%0d", o_rdata, o_err, o_lat, e.rdata, e.err, e.lat);
    end
    issue(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h00000080, 1'b0, 3, 0);
    e = sb.pop_front();
    n_cmp++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== e.lat) begin
      n_fail++;
      $display("FAIL lbu: rdata=%h err=%b lat=%0d required %h/%b/%0d", o_rdata, o_err, o_lat, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_half();
    exp_t e;
    issue(1'b1, 2'b01, 1'b0, 32'h302, 32'hABCD8001, 32'h0, 1'b0, 2, 0);
    e = sb.pop_front();
    n_cmp++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== e.lat || o_nwr !== 1 || o_wd !== 32'h80018001 || o_sz !== 2'b01) begin
      n_fail++;
      $display("FAIL sh_store: rdata=%h err=%b lat=%0d wr=%0d wdata=%h size=%b required %h/%b/%0d/1/80018001/01",
               o_rdata, o_err, o_lat, o_nwr, o_wd, o_sz, e.rdata, e.err, e.lat);
    end
    issue(1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 32'hFFFF8001, 1'b0, 3, 0);
    e = sb.pop_front();
    n_cmp++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== e.lat) begin
      n_fail++;
      $display("FAIL lh_signed: rdata=%h err=%b lat=%0d required %h/%b/%0d", o_rdata, o_err, o_lat, e.rdata, e.err, e.lat);
    end
    issue(1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 32'h00008001, 1'b0, 3, 0);
    e = sb.pop_front();
    n_cmp++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== e.lat) begin
      n_fail++;
      $display("FAIL lhu: rdata=%h err=%b lat=%0d required %h/%b/%0d", o_rdata, o_err, o_lat, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_errors();
    exp_t e;
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'hCAFEF00D, 32'h0, 1'b1, 2, 0);
    e = sb.pop_front();
    n_cmp++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== e.lat || o_nwr !== 0) begin
      n_fail++;
      $display("FAIL misaligned_sw: rdata=%h err=%b lat=%0d wr=%0d required %h/%b/%0d/0",
               o_rdata, o_err, o_lat, o_nwr, e.rdata, e.err, e.lat);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
    e = sb.pop_front();
    n_cmp++;
    if (o_rdata !== e.rdata || o_err !== e.err) begin
      n_fail++;
      $display("FAIL after_misaligned_lw: rdata=%h err=%b required %h/%b", o_rdata, o_err, e.rdata, e.err);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 32'h0, 1'b1, 2, 0);
    e = sb.pop_front();
    n_cmp++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== e.lat || o_nrd !== 0) begin
      n_fail++;
      $display("FAIL range_lw: rdata=%h err=%b lat=%0d rd=%0d required %h/%b/%0d/0",
               o_rdata, o_err, o_lat, o_nrd, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_illegal_stall();
    exp_t e;
    issue(1'b1, 2'b11, 1'b0, 32'h100, 32'h55555555, 32'h0, 1'b1, 1, 5);
    e = sb.pop_front();
    n_cmp++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== e.lat) begin
      n_fail++;
      $display("FAIL illegal_resp: rdata=%h err=%b lat=%0d required %h/%b/%0d", o_rdata, o_err, o_lat, e.rdata, e.err, e.lat);
    end
    n_cmp++;
    if (o_nwr !== 0 || o_nrd !== 0 || o_stable !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_stall: wr=%0d rd=%0d stable=%b required 0/0/1", o_nwr, o_nrd, o_stable);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int d1, d2;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h400; req_wdata = 32'h01020304; resp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (req_ready) acc.push_back(i);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    resp_ready = 1'b0;
    d1 = (acc.size() >= 3) ? acc[1] - acc[0] : -1;
    d2 = (acc.size() >= 3) ? acc[2] - acc[1] : -1;
    n_cmp++;
    if (d1 !== 3 || d2 !== 3) begin
      n_fail++;
      $display("FAIL back_to_back: accept spacing %0d,%0d (count %0d) required 3,3", d1, d2, acc.size());
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h100; req_wdata = 32'h11111111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++;
    if (mem_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_access_wr: mem_wr=%b required 1", mem_wr);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drops_wr: mem_wr=%b required 0", mem_wr);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: req_ready=%b resp_valid=%b required 1/0", req_ready, resp_valid);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
    e = sb.pop_front();
    n_cmp++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat !== e.lat) begin
      n_fail++;
      $display("FAIL reset_mem_unchanged: rdata=%h err=%b lat=%0d required %h/%b/%0d",
               o_rdata, o_err, o_lat, e.rdata, e.err, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_illegal_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
